// File: rtl/triangle_dispatch.sv
// Round-robin dispatcher feeding two triangle requesters into one rasterizer and counting its pixels.
// Optional degenerate-triangle culling: define TRIANGLE_DISPATCH_CULL_EN.
package triangle_dispatch_pkg;
    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] z;
        logic [31:0] w;
    } Vector4_t;
endpackage

module triangle_dispatch
    import triangle_dispatch_pkg::*;
#(
    parameter int COUNT_W = 24
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [1:0]         i_req_valid,
    input  Vector4_t           i_req0_v1,
    input  Vector4_t           i_req0_v2,
    input  Vector4_t           i_req0_v3,
    input  Vector4_t           i_req1_v1,
    input  Vector4_t           i_req1_v2,
    input  Vector4_t           i_req1_v3,
    output logic [1:0]         o_req_ready,
    output logic               o_rast_start,
    output Vector4_t           o_rast_v1,
    output Vector4_t           o_rast_v2,
    output Vector4_t           o_rast_v3,
    input  logic               i_rast_ready,
    input  logic               i_rast_valid,
    output logic               o_done,
    output logic               o_done_id,
    output logic [COUNT_W-1:0] o_done_pixels,
    output logic               o_busy
);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t             state_q;
    logic               rr_q;
    logic               id_q;
    logic [COUNT_W-1:0] cnt_q, cnt_d;
    Vector4_t           v1_q, v2_q, v3_q;

    logic [1:0] grant;
    logic       gnt_id;
    Vector4_t   sel_v1, sel_v2, sel_v3;
    logic       cull;

    // Grant is combinational so a requester is accepted in the same cycle it presents.
    always_comb begin
        grant = 2'b00;
        if (state_q == IDLE) begin
            case (i_req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign gnt_id = grant[1];
    assign sel_v1 = gnt_id ? i_req1_v1 : i_req0_v1;
    assign sel_v2 = gnt_id ? i_req1_v2 : i_req0_v2;
    assign sel_v3 = gnt_id ? i_req1_v3 : i_req0_v3;

`ifdef TRIANGLE_DISPATCH_CULL_EN
    assign cull = ((sel_v1.x == sel_v2.x) && (sel_v2.x == sel_v3.x)) ||
                  ((sel_v1.y == sel_v2.y) && (sel_v2.y == sel_v3.y));
`else
    assign cull = 1'b0;
`endif

    assign cnt_d = (i_rast_valid && (cnt_q != {COUNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
            v1_q    <= '0;
            v2_q    <= '0;
            v3_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (|grant) begin
                    v1_q    <= sel_v1;
                    v2_q    <= sel_v2;
                    v3_q    <= sel_v3;
                    id_q    <= gnt_id;
                    cnt_q   <= '0;
                    rr_q    <= ~gnt_id;
                    state_q <= cull ? DONE : START;
                end
                START: if (i_rast_ready) state_q <= RUN;
                RUN: begin
                    cnt_q <= cnt_d;
                    if (i_rast_ready && !i_rast_valid) state_q <= DONE;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_req_ready   = grant;
    assign o_rast_start  = (state_q == START) && i_rast_ready;
    assign o_rast_v1     = v1_q;
    assign o_rast_v2     = v2_q;
    assign o_rast_v3     = v3_q;
    assign o_done        = (state_q == DONE);
    assign o_done_id     = id_q;
    assign o_done_pixels = cnt_q;
    assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_triangle_dispatch.sv
// Directed + randomized bench for triangle_dispatch; acts as requesters and a simple rasterizer.
module tb_triangle_dispatch;
    import triangle_dispatch_pkg::*;

    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    req_valid;
    Vector4_t      r0v1, r0v2, r0v3, r1v1, r1v2, r1v3;
    logic [1:0]    req_ready;
    logic          rast_start;
    Vector4_t      rv1, rv2, rv3;
    logic          rast_ready, rast_valid;
    logic          done, done_id;
    logic [CW-1:0] done_pix;
    logic          busy;

    int total = 0;
    int bad = 0;
    bit rr_m;

    triangle_dispatch #(.COUNT_W(CW)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_req_valid(req_valid),
        .i_req0_v1(r0v1), .i_req0_v2(r0v2), .i_req0_v3(r0v3),
        .i_req1_v1(r1v1), .i_req1_v2(r1v2), .i_req1_v3(r1v3),
        .o_req_ready(req_ready), .o_rast_start(rast_start),
        .o_rast_v1(rv1), .o_rast_v2(rv2), .o_rast_v3(rv3),
        .i_rast_ready(rast_ready), .i_rast_valid(rast_valid),
        .o_done(done), .o_done_id(done_id), .o_done_pixels(done_pix), .o_busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic Vector4_t mkv(input logic [31:0] x, input logic [31:0] y);
        Vector4_t v;
        v.x = x; v.y = y; v.z = 32'h3F800000; v.w = 32'h3F800000;
        return v;
    endfunction

    function automatic Vector4_t rndv();
        Vector4_t v;
        v.x = $urandom; v.y = $urandom; v.z = $urandom; v.w = $urandom;
        return v;
    endfunction

    task automatic check_idle_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, rast_start, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_id"}, done_id, 0);
        chk({tag, "_pix"}, done_pix, 0);
        chk({tag, "_v1"}, rv1, 0);
        chk({tag, "_v3"}, rv3, 0);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    task automatic do_reset();
        req_valid = 2'b00; rast_valid = 1'b0; rast_ready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        rr_m = 1'b0;
    endtask

    // One full triangle: request, arbitration, start, pixel stream, completion.
    task automatic transact(input logic [1:0] vld, input Vector4_t a1, a2, a3,
                            input Vector4_t b1, b2, b3, input int npix,
                            input int stall, input int abort_at);
        logic [1:0] expg;
        bit         gid, cull;
        Vector4_t   e1, e2, e3;
        int         cnt, exp_pix;
        req_valid = vld;
        r0v1 = a1; r0v2 = a2; r0v3 = a3;
        r1v1 = b1; r1v2 = b2; r1v3 = b3;
        rast_ready = 1'b1; rast_valid = 1'b0;
        #1;
        if (vld == 2'b11) expg = rr_m ? 2'b10 : 2'b01;
        else              expg = vld;
        chk("grant", req_ready, expg);
        gid = expg[1];
        rr_m = ~gid;
        e1 = gid ? b1 : a1; e2 = gid ? b2 : a2; e3 = gid ? b3 : a3;
`ifdef TRIANGLE_DISPATCH_CULL_EN
        cull = (e1.x == e2.x && e2.x == e3.x) || (e1.y == e2.y && e2.y == e3.y);
`else
        cull = 1'b0;
`endif
        @(negedge clk);
        if (cull) begin
            #1;
            chk("cull_done", done, 1);
            chk("cull_pix", done_pix, 0);
            chk("cull_nostart", rast_start, 0);
            chk("cull_id", done_id, gid);
            @(negedge clk);
            req_valid = 2'b00;
            return;
        end
        for (int i = 0; i < stall; i++) begin
            rast_ready = 1'b0; rast_valid = 1'b1;
            #1;
            chk("stall_start", rast_start, 0);
            chk("busy_ready", req_ready, 0);
            @(negedge clk);
        end
        rast_ready = 1'b1; rast_valid = 1'b0;
        #1;
        chk("start", rast_start, 1);
        chk("busy", busy, 1);
        chk("v1", rv1, e1);
        chk("v2", rv2, e2);
        chk("v3", rv3, e3);
        @(negedge clk);
        rast_ready = 1'b0;
        cnt = 0;
        while (cnt < npix) begin
            rast_valid = ($urandom_range(0, 3) != 0);
            if (rast_valid) cnt++;
            @(negedge clk);
            if (abort_at >= 0 && cnt == abort_at) begin
                rast_valid = 1'b0; rast_ready = 1'b1; req_valid = 2'b00;
                rst_n = 1'b0;
                @(negedge clk);
                #1;
                check_idle_zero("abort");
                rst_n = 1'b1;
                rr_m = 1'b0;
                @(negedge clk);
                #1;
                chk("abort_nodone", done, 0);
                return;
            end
        end
        rast_valid = 1'b0; rast_ready = 1'b1;
        @(negedge clk);
        #1;
        exp_pix = (cnt > SAT) ? SAT : cnt;
        chk("done", done, 1);
        chk("done_id", done_id, gid);
        chk("done_pix", done_pix, exp_pix);
        chk("done_noready", req_ready, 0);
        chk("done_v1", rv1, e1);
        @(negedge clk);
        #1;
        chk("done_once", done, 0);
        chk("idle", busy, 0);
        req_valid = 2'b00;
    endtask

    initial begin
        Vector4_t z;
        Vector4_t p1, p2, p3, q1, q2, q3;
        logic [1:0] v;
        z = '0;
        r0v1 = z; r0v2 = z; r0v3 = z; r1v1 = z; r1v2 = z; r1v3 = z;
        do_reset();
        #1;
        check_idle_zero("reset");

        // Small triangle from requester 0, six pixels.
        p1 = mkv(0, 0); p2 = mkv(2, 0); p3 = mkv(0, 1);
        q1 = mkv(9, 1); q2 = mkv(3, 7); q3 = mkv(4, 2);
        transact(2'b01, p1, p2, p3, q1, q2, q3, 6, 0, -1);

        // Both valid straight after reset: 0 then 1.
        do_reset();
        transact(2'b11, p1, p2, p3, q1, q2, q3, 2, 0, -1);
        transact(2'b11, p1, p2, p3, q1, q2, q3, 3, 0, -1);

        // Sustained contention alternates.
        for (int i = 0; i < 4; i++)
            transact(2'b11, rndv(), rndv(), rndv(), rndv(), rndv(), rndv(), 1 + i, 0, -1);

        // Rasterizer busy for five cycles in START.
        transact(2'b10, p1, p2, p3, q1, q2, q3, 2, 5, -1);

        // Counter saturation.
        transact(2'b01, p1, p2, p3, q1, q2, q3, SAT + 5, 0, -1);

        // Reset mid-RUN, then a fresh triangle counts from zero.
        transact(2'b01, p1, p2, p3, q1, q2, q3, 10, 0, 3);
        transact(2'b01, p1, p2, p3, q1, q2, q3, 4, 0, -1);

        // Degenerate triangle: all x equal to 5.0.
        transact(2'b01, mkv(32'h40A00000, 0), mkv(32'h40A00000, 1), mkv(32'h40A00000, 2),
                 q1, q2, q3, 3, 0, -1);

        // Randomized traffic.
        for (int i = 0; i < 12; i++) begin
            v = 2'($urandom_range(1, 3));
            transact(v, rndv(), rndv(), rndv(), rndv(), rndv(), rndv(),
                     int'($urandom_range(0, 18)), int'($urandom_range(0, 3)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
